overlay_sequencer: RTL and testbench

- Frame-synchronous scheduler for the on-screen prompt overlays: title, countdown digit, "GO" and result banner.
- Drives the `en` input of each sprite overlay controller and the countdown digit select.
- All enable changes land only at a frame boundary in vertical blanking, so no overlay tears mid-frame.
- Sits between the game-control logic (start/stop pulses) and the VGA overlay controllers; shares their hCount/vCount.

---
 rtl/overlay_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_overlay_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_sequencer.sv
// -----------------------------------------------------------------------------
// overlay_sequencer
//
// Frame-synchronous scheduler for the on-screen prompt overlays (title,
// countdown digit, "GO", result banner). It generates one frame tick per frame
// from the shared VGA raster counters and only ever changes an overlay enable
// at that tick, which sits on the first vertical-blanking line. As a result no
// overlay switches on or off part way through a visible frame.
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous, active-high reset
//   hCount_i[9:0]   current pixel column from the VGA timing generator
//   vCount_i[9:0]   current line from the VGA timing generator
//   start_i         one-clk start request pulse from game control
//   stop_i          one-clk game-over pulse from game control
//   frame_tick_o    one-clk pulse per frame (registered)
//   title_en_o      title overlay enable
//   count_en_o      countdown overlay enable
//   count_digit_o   digit shown by the countdown overlay (held while idle)
//   go_en_o         "GO" overlay enable
//   result_en_o     result overlay enable
//   play_active_o   gameplay running
//   state_o[2:0]    TITLE=0, COUNT=1, GO=2, PLAY=3, RESULT=4
//
// Build option:
//   OVERLAY_SEQ_BLINK_EN  when defined, title_en blinks with a half-period of
//                         BLINK_FRAMES frames while in TITLE. When undefined,
//                         title_en is held at 1 for the whole TITLE state.
// -----------------------------------------------------------------------------
module overlay_sequencer #(
  parameter int unsigned V_TICK        = 480,
  parameter int unsigned BLINK_FRAMES  = 30,
  parameter int unsigned STEP_FRAMES   = 60,
  parameter int unsigned COUNT_START   = 3,
  parameter int unsigned GO_FRAMES     = 30,
  parameter int unsigned RESULT_FRAMES = 120
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] hCount_i,
  input  logic [9:0] vCount_i,
  input  logic       start_i,
  input  logic       stop_i,
  output logic       frame_tick_o,
  output logic       title_en_o,
  output logic       count_en_o,
  output logic [1:0] count_digit_o,
  output logic       go_en_o,
  output logic       result_en_o,
  output logic       play_active_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_TITLE  = 3'd0,
    ST_COUNT  = 3'd1,
    ST_GO     = 3'd2,
    ST_PLAY   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  localparam logic [9:0] V_TICK_L    = 10'(V_TICK);
  localparam logic [7:0] STEP_LAST   = 8'(STEP_FRAMES - 1);
  localparam logic [7:0] GO_LAST     = 8'(GO_FRAMES - 1);
  localparam logic [7:0] RESULT_MIN  = 8'(RESULT_FRAMES);
  localparam logic [1:0] DIGIT_START = 2'(COUNT_START);
`ifdef OVERLAY_SEQ_BLINK_EN
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);
`endif

  state_t     state_q;
  logic [7:0] fcnt_q;
  logic       title_en_q;
  logic       count_en_q;
  logic [1:0] count_digit_q;
  logic       go_en_q;
  logic       result_en_q;
  logic       play_active_q;
  logic       startPend_q;
  logic       stopPend_q;
  logic       tickLine_q;
  logic       frameTick_q;

  logic       tickLine;
  logic       frameTick_d;
  logic       startPend_d;
  logic       stopPend_d;
  logic [7:0] fcnt_d;

  // The tick line is the first pixel of the first blanking line. The raster
  // may hold hCount for several clocks per pixel, so the tick itself is taken
  // from the rising edge of this condition rather than the level.
  assign tickLine    = (hCount_i == 10'd0) && (vCount_i == V_TICK_L);
  assign frameTick_d = tickLine & ~tickLine_q;

  // Request qualification and the saturating frame counter increment.
  // A start is only meaningful in TITLE, or in RESULT once the banner has
  // been held long enough; a stop only in PLAY. Anything else is dropped
  // here so it can never be remembered into a later state. The pending
  // value already ORs in the live pulse, so a pulse that lands in the tick
  // cycle itself is honoured at that tick.
  always_comb begin
    startPend_d = startPend_q;
    stopPend_d  = stopPend_q;
    if ((state_q == ST_TITLE) ||
        ((state_q == ST_RESULT) && (fcnt_q >= RESULT_MIN))) begin
      startPend_d = startPend_q | start_i;
    end
    if (state_q == ST_PLAY) begin
      stopPend_d = stopPend_q | stop_i;
    end
    fcnt_d = (fcnt_q == 8'hFF) ? fcnt_q : (fcnt_q + 8'd1);
  end

  // Frame tick edge detector: remembers the previous tick-line level and
  // emits a single registered pulse when it first goes high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tickLine_q  <= 1'b0;
      frameTick_q <= 1'b0;
    end else begin
      tickLine_q  <= tickLine;
      frameTick_q <= frameTick_d;
    end
  end

  // Overlay state machine. Requests are accumulated every clock, but state,
  // counter and enables only move in the frame-tick cycle, so every change
  // appears on the outputs in the clock right after the tick. Every state
  // change clears the frame counter and both pending requests.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_TITLE;
      fcnt_q        <= 8'd0;
      title_en_q    <= 1'b1;
      count_en_q    <= 1'b0;
      count_digit_q <= 2'd0;
      go_en_q       <= 1'b0;
      result_en_q   <= 1'b0;
      play_active_q <= 1'b0;
      startPend_q   <= 1'b0;
      stopPend_q    <= 1'b0;
    end else begin
      startPend_q <= startPend_d;
      stopPend_q  <= stopPend_d;
      if (frameTick_q) begin
        fcnt_q <= fcnt_d;
        case (state_q)
          ST_TITLE: begin
            if (startPend_d) begin
              state_q       <= ST_COUNT;
              fcnt_q        <= 8'd0;
              startPend_q   <= 1'b0;
              stopPend_q    <= 1'b0;
              title_en_q    <= 1'b0;
              count_en_q    <= 1'b1;
              count_digit_q <= DIGIT_START;
            end
`ifdef OVERLAY_SEQ_BLINK_EN
            else if (fcnt_q == BLINK_LAST) begin
              title_en_q <= ~title_en_q;
              fcnt_q     <= 8'd0;
            end
`else
            else begin
              title_en_q <= 1'b1;
            end
`endif
          end

          // Each digit is shown for STEP_FRAMES ticks; digit 1 hands over
          // to GO instead of decrementing to 0.
          ST_COUNT: begin
            if (fcnt_q == STEP_LAST) begin
              fcnt_q <= 8'd0;
              if (count_digit_q == 2'd1) begin
                state_q     <= ST_GO;
                startPend_q <= 1'b0;
                stopPend_q  <= 1'b0;
                count_en_q  <= 1'b0;
                go_en_q     <= 1'b1;
              end else begin
                count_digit_q <= count_digit_q - 2'd1;
              end
            end
          end

          ST_GO: begin
            if (fcnt_q == GO_LAST) begin
              state_q       <= ST_PLAY;
              fcnt_q        <= 8'd0;
              startPend_q   <= 1'b0;
              stopPend_q    <= 1'b0;
              go_en_q       <= 1'b0;
              play_active_q <= 1'b1;
            end
          end

          ST_PLAY: begin
            if (stopPend_d) begin
              state_q       <= ST_RESULT;
              fcnt_q        <= 8'd0;
              startPend_q   <= 1'b0;
              stopPend_q    <= 1'b0;
              play_active_q <= 1'b0;
              result_en_q   <= 1'b1;
            end
          end

          // The banner has no timeout; only an accepted start leaves it.
          ST_RESULT: begin
            if (startPend_d) begin
              state_q       <= ST_COUNT;
              fcnt_q        <= 8'd0;
              startPend_q   <= 1'b0;
              stopPend_q    <= 1'b0;
              result_en_q   <= 1'b0;
              count_en_q    <= 1'b1;
              count_digit_q <= DIGIT_START;
            end
          end

          // Unused encodings fall back to the reset picture.
          default: begin
            state_q       <= ST_TITLE;
            fcnt_q        <= 8'd0;
            startPend_q   <= 1'b0;
            stopPend_q    <= 1'b0;
            title_en_q    <= 1'b1;
            count_en_q    <= 1'b0;
            count_digit_q <= 2'd0;
            go_en_q       <= 1'b0;
            result_en_q   <= 1'b0;
            play_active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign frame_tick_o  = frameTick_q;
  assign title_en_o    = title_en_q;
  assign count_en_o    = count_en_q;
  assign count_digit_o = count_digit_q;
  assign go_en_o       = go_en_q;
  assign result_en_o   = result_en_q;
  assign play_active_o = play_active_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_overlay_sequencer.sv
// -----------------------------------------------------------------------------
// tb_overlay_sequencer
//
// Directed bench for overlay_sequencer. A small raster (8 pixels x 6 lines,
// 4 clocks per pixel, tick on line 4) gives a 192-clock frame. Each scenario
// task drives its own stimulus and checks against hand-computed values.
// Works with and without OVERLAY_SEQ_BLINK_EN.
// -----------------------------------------------------------------------------
module tb_overlay_sequencer;

  localparam logic [9:0] H_TOTAL     = 10'd8;
  localparam logic [9:0] V_TOTAL     = 10'd6;
  localparam int         FRAME_CLKS  = 192;
  localparam int         TICK_BOUND  = 400;

  logic       clk;
  logic       rst;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       start;
  logic       stop;
  logic       frameTick;
  logic       titleEn;
  logic       countEn;
  logic [1:0] countDigit;
  logic       goEn;
  logic       resultEn;
  logic       playActive;
  logic [2:0] state;

  int compared;
  int mismatched;
  int pixDiv;

  // Observed output picture: {state, title, count, digit, go, result, play}.
  logic [9:0] obs;
  assign obs = {state, titleEn, countEn, countDigit, goEn, resultEn, playActive};

  overlay_sequencer #(
    .V_TICK       (4),
    .BLINK_FRAMES (2),
    .STEP_FRAMES  (2),
    .COUNT_START  (3),
    .GO_FRAMES    (1),
    .RESULT_FRAMES(2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .hCount_i     (hCount),
    .vCount_i     (vCount),
    .start_i      (start),
    .stop_i       (stop),
    .frame_tick_o (frameTick),
    .title_en_o   (titleEn),
    .count_en_o   (countEn),
    .count_digit_o(countDigit),
    .go_en_o      (goEn),
    .result_en_o  (resultEn),
    .play_active_o(playActive),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raster generator, advanced on the falling edge so the DUT sees stable
  // counters at every rising edge.
  initial begin
    hCount = 10'd0;
    vCount = 10'd0;
    pixDiv = 0;
    forever begin
      @(negedge clk);
      if (pixDiv == 3) begin
        pixDiv = 0;
        if (hCount == H_TOTAL - 10'd1) begin
          hCount = 10'd0;
          vCount = (vCount == V_TOTAL - 10'd1) ? 10'd0 : vCount + 10'd1;
        end else begin
          hCount = hCount + 10'd1;
        end
      end else begin
        pixDiv = pixDiv + 1;
      end
    end
  end

  function automatic logic [9:0] pack(input logic [2:0] st, input logic t,
                                      input logic c, input logic [1:0] d,
                                      input logic g, input logic r,
                                      input logic p);
    return {st, t, c, d, g, r, p};
  endfunction

  task automatic nextClk();
    @(posedge clk);
    #1;
  endtask

  // Advance until the sample point of a frame-tick cycle.
  task automatic waitTick();
    int n;
    n = 0;
    do begin
      nextClk();
      n++;
    end while (!frameTick && n < TICK_BOUND);
    compared++;
    if (frameTick !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL tick_timeout: frame_tick=%b after %0d clks, required 1", frameTick, n);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    nextClk();
    start = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    repeat (3) nextClk();
    compared++;
    if (obs !== pack(3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b required %b", obs,
               pack(3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    end
    compared++;
    if (frameTick !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_tick: got %b required 0", frameTick);
    end
    rst = 1'b0;
    nextClk();
    compared++;
    if (obs !== pack(3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL post_release: got %b required %b", obs,
               pack(3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  // title_en as seen in the tick cycle of ticks 1..5 after reset.
  task automatic test_title_blink();
    logic [4:0] expTitle;
    $display("[TB] test_title_blink");
`ifdef OVERLAY_SEQ_BLINK_EN
    expTitle = 5'b10011;
`else
    expTitle = 5'b11111;
`endif
    for (int i = 0; i < 5; i++) begin
      waitTick();
      compared++;
      if ({state, titleEn} !== {3'd0, expTitle[i]}) begin
        mismatched++;
        $display("[TB] FAIL title_tick%0d: got state=%0d title=%b required state=0 title=%b",
                 i + 1, state, titleEn, expTitle[i]);
      end
    end
  endtask

  task automatic test_frame_tick();
    int ticks;
    $display("[TB] test_frame_tick");
    ticks = 0;
    repeat (3 * FRAME_CLKS) begin
      nextClk();
      if (frameTick === 1'b1) ticks++;
    end
    compared++;
    if (ticks != 3) begin
      mismatched++;
      $display("[TB] FAIL tick_count: got %0d tick clks in 3 frames, required 3", ticks);
    end
  endtask

  task automatic test_ignored_in_title();
    $display("[TB] test_ignored_in_title");
    waitTick();
    repeat (40) nextClk();
    stop = 1'b1;
    nextClk();
    stop = 1'b0;
    waitTick();
    nextClk();
    compared++;
    if ({state, resultEn, playActive} !== {3'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL stop_in_title: got state=%0d result=%b play=%b required 0/0/0",
               state, resultEn, playActive);
    end
  endtask

  task automatic test_count_sequence();
    logic [1:0] expDigit;
    $display("[TB] test_count_sequence");
    waitTick();
    repeat (50) nextClk();
    pulseStart();
    repeat (5) nextClk();
    compared++;
    if ({state, countEn} !== {3'd0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL start_midframe: got state=%0d count_en=%b required 0/0", state, countEn);
    end
    waitTick();
    compared++;
    if (state !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL start_tick_cycle: got state=%0d required 0", state);
    end
    nextClk();
    compared++;
    if (obs !== pack(3'd1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL count_entry: got %b required %b", obs,
               pack(3'd1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0));
    end
    for (int i = 1; i <= 5; i++) begin
      waitTick();
      nextClk();
      expDigit = 2'(3 - i / 2);
      compared++;
      if (obs !== pack(3'd1, 1'b0, 1'b1, expDigit, 1'b0, 1'b0, 1'b0)) begin
        mismatched++;
        $display("[TB] FAIL count_tick%0d: got %b required %b", i, obs,
                 pack(3'd1, 1'b0, 1'b1, expDigit, 1'b0, 1'b0, 1'b0));
      end
      if (i == 2) begin
        repeat (30) nextClk();
        pulseStart();
      end
    end
    waitTick();
    nextClk();
    compared++;
    if (obs !== pack(3'd2, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL go_entry: got %b required %b", obs,
               pack(3'd2, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0));
    end
    waitTick();
    nextClk();
    compared++;
    if (obs !== pack(3'd3, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1)) begin
      mismatched++;
      $display("[TB] FAIL play_entry: got %b required %b", obs,
               pack(3'd3, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1));
    end
  endtask

  task automatic test_stop_on_tick();
    $display("[TB] test_stop_on_tick");
    waitTick();
    nextClk();
    compared++;
    if (obs !== pack(3'd3, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1)) begin
      mismatched++;
      $display("[TB] FAIL play_hold: got %b required %b", obs,
               pack(3'd3, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1));
    end
    waitTick();
    stop = 1'b1;
    nextClk();
    stop = 1'b0;
    compared++;
    if (obs !== pack(3'd4, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL stop_on_tick: got %b required %b", obs,
               pack(3'd4, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_result_restart();
    $display("[TB] test_result_restart");
    repeat (40) nextClk();
    pulseStart();
    waitTick();
    nextClk();
    compared++;
    if (obs !== pack(3'd4, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL result_fcnt0_start: got %b required %b", obs,
               pack(3'd4, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0));
    end
    repeat (40) nextClk();
    pulseStart();
    waitTick();
    nextClk();
    compared++;
    if (obs !== pack(3'd4, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL result_fcnt1_start: got %b required %b", obs,
               pack(3'd4, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0));
    end
    repeat (40) nextClk();
    pulseStart();
    repeat (5) nextClk();
    compared++;
    if (state !== 3'd4) begin
      mismatched++;
      $display("[TB] FAIL restart_midframe: got state=%0d required 4", state);
    end
    waitTick();
    nextClk();
    compared++;
    if (obs !== pack(3'd1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL restart_count: got %b required %b", obs,
               pack(3'd1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_reset_mid_count();
    $display("[TB] test_reset_mid_count");
    waitTick();
    nextClk();
    waitTick();
    nextClk();
    compared++;
    if (obs !== pack(3'd1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL count_digit2: got %b required %b", obs,
               pack(3'd1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0));
    end
    repeat (10) nextClk();
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (obs !== pack(3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got %b required %b", obs,
               pack(3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    end
    nextClk();
    rst = 1'b0;
    waitTick();
    nextClk();
    compared++;
    if (obs !== pack(3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL after_reset_tick: got %b required %b", obs,
               pack(3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    test_reset();
    test_title_blink();
    test_frame_tick();
    test_ignored_in_title();
    test_count_sequence();
    test_stop_on_tick();
    test_result_restart();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
